// File: rtl/regfile_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_operand_sequencer_if
//   Bundles every non-clock/reset signal of the operand sequencer: the decode
//   handshake, the register-file read/write ports, the issue handshake, the
//   writeback input, the busy scoreboard and an FSM debug view.
//
//   Handshakes (dec_* and iss_*): a transfer happens on a rising clk edge where
//   valid && ready are both 1. A producer holds valid and its payload stable
//   until that edge. The ready signal may depend on state but never on valid.
//
//   Modports
//     master : the sequencer side (drives dec_ready, rf_*addr/write, iss_*,
//              busy_mask, dbg_state)
//     slave  : the environment side (decoder, register file, issue consumer,
//              writeback source)
// ---------------------------------------------------------------------------
interface regfile_operand_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int NREGS = 1 << ADDR_W;

    // decode handshake
    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_src1;
    logic [ADDR_W-1:0] dec_src2;
    logic [ADDR_W-1:0] dec_dst;
    logic              dec_wr;
    // register file ports
    logic [ADDR_W-1:0] rf_read_addr1;
    logic [ADDR_W-1:0] rf_read_addr2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;
    // issue handshake
    logic              iss_valid;
    logic              iss_ready;
    logic [DATA_W-1:0] iss_op1;
    logic [DATA_W-1:0] iss_op2;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_wr;
    // writeback
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // scoreboard and FSM state view
    logic [NREGS-1:0]  busy_mask;
    logic [1:0]        dbg_state;

    modport master (
        input  dec_valid, dec_src1, dec_src2, dec_dst, dec_wr,
        input  rf_read_data1, rf_read_data2,
        input  iss_ready,
        input  wb_valid, wb_addr, wb_data,
        output dec_ready,
        output rf_read_addr1, rf_read_addr2,
        output rf_write_addr, rf_write_data, rf_write_enable,
        output iss_valid, iss_op1, iss_op2, iss_dst, iss_wr,
        output busy_mask, dbg_state
    );

    modport slave (
        output dec_valid, dec_src1, dec_src2, dec_dst, dec_wr,
        output rf_read_data1, rf_read_data2,
        output iss_ready,
        output wb_valid, wb_addr, wb_data,
        input  dec_ready,
        input  rf_read_addr1, rf_read_addr2,
        input  rf_write_addr, rf_write_data, rf_write_enable,
        input  iss_valid, iss_op1, iss_op2, iss_dst, iss_wr,
        input  busy_mask, dbg_state
    );
endinterface

// File: rtl/regfile_operand_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_operand_sequencer
//   Front end of the 8x8 register file. Accepts one decoded instruction at a
//   time, reads its two source operands (stalling while a source has an
//   outstanding write, bypassing a same-cycle writeback), issues the operand
//   pair downstream and turns writebacks into register-file writes plus
//   scoreboard clears.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    regfile_operand_sequencer_if.master (dec_*, rf_*, iss_*, wb_*,
//            busy_mask, dbg_state)
//
//   FSM: IDLE -> FETCH -> HOLD -> IDLE, exposed on bus.dbg_state
//   (0 = IDLE, 1 = FETCH, 2 = HOLD).
// ---------------------------------------------------------------------------
module regfile_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    regfile_operand_sequencer_if.master   bus
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // latched instruction
    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic              wr_q;

    // issue registers
    logic              iss_valid_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [ADDR_W-1:0] iss_dst_q;
    logic              iss_wr_q;

    logic [NREGS-1:0]  busy_q, busy_d;

    logic              hit1, hit2, blk1, blk2;
    logic [DATA_W-1:0] opnd1, opnd2;
    logic              accept, capture, release_iss;

    // Operand resolution: a writeback to a source in the same cycle both
    // unblocks it and supplies the value (the register file only sees that
    // write at the coming edge).
    always_comb begin
        hit1  = bus.wb_valid && (bus.wb_addr == src1_q);
        hit2  = bus.wb_valid && (bus.wb_addr == src2_q);
        blk1  = busy_q[src1_q] && !hit1;
        blk2  = busy_q[src2_q] && !hit2;
        opnd1 = hit1 ? bus.wb_data : bus.rf_read_data1;
        opnd2 = hit2 ? bus.wb_data : bus.rf_read_data2;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        release_iss = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dec_valid) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!blk1 && !blk2) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.iss_ready) begin
                    release_iss = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard: clear on writeback first, then set for the issuing
    // instruction, so a same-edge set and clear of one register leaves it
    // busy (the new producer is still outstanding). The busy bit of the
    // instruction's own dst is set only at capture, after its sources were
    // read, so src == dst never stalls on itself.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid)
            busy_d[bus.wb_addr] = 1'b0;
        if (capture && wr_q)
            busy_d[dst_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_q       <= '0;
            wr_q        <= 1'b0;
            iss_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            iss_dst_q   <= '0;
            iss_wr_q    <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (accept) begin
                src1_q <= bus.dec_src1;
                src2_q <= bus.dec_src2;
                dst_q  <= bus.dec_dst;
                wr_q   <= bus.dec_wr;
            end
            if (capture) begin
                op1_q       <= opnd1;
                op2_q       <= opnd2;
                iss_dst_q   <= dst_q;
                iss_wr_q    <= wr_q;
                iss_valid_q <= 1'b1;
            end else if (release_iss) begin
                iss_valid_q <= 1'b0;
            end
        end
    end

    // Read addresses come straight from the latched sources; they are only
    // meaningful in FETCH but holding them elsewhere costs nothing.
    assign bus.rf_read_addr1   = src1_q;
    assign bus.rf_read_addr2   = src2_q;

    // Writeback is a pure passthrough to the register-file write port.
    assign bus.rf_write_enable = bus.wb_valid;
    assign bus.rf_write_addr   = bus.wb_addr;
    assign bus.rf_write_data   = bus.wb_data;

    assign bus.dec_ready       = (state_q == IDLE);
    assign bus.iss_valid       = iss_valid_q;
    assign bus.iss_op1         = op1_q;
    assign bus.iss_op2         = op2_q;
    assign bus.iss_dst         = iss_dst_q;
    assign bus.iss_wr          = iss_wr_q;
    assign bus.busy_mask       = busy_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_operand_sequencer
//   Directed scenarios followed by randomized instructions and writebacks.
//   A behavioural model (register values and busy flags as plain arrays)
//   predicts, cycle by cycle, when each instruction may issue and with which
//   operand values. The register file itself is an array in the bench written
//   only through the DUT's write port.
// ---------------------------------------------------------------------------
module tb_regfile_operand_sequencer;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_operand_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    regfile_operand_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    // register file environment
    logic [DW-1:0] rf_mem [NR];
    assign ifc.rf_read_data1 = rf_mem[ifc.rf_read_addr1];
    assign ifc.rf_read_data2 = rf_mem[ifc.rf_read_addr2];
    always @(posedge clk)
        if (ifc.rf_write_enable) rf_mem[ifc.rf_write_addr] <= ifc.rf_write_data;

    // reference model
    logic [DW-1:0] ref_regs [NR];
    logic [NR-1:0] ref_busy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply the driven writeback to the model at the edge, plus an
    // optional scoreboard set (applied after the clear), then sample at negedge.
    task automatic tick(input bit set_en, input logic [AW-1:0] set_a);
        logic v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        v = ifc.wb_valid;
        a = ifc.wb_addr;
        d = ifc.wb_data;
        @(posedge clk);
        if (v) begin
            ref_regs[a] = d;
            ref_busy[a] = 1'b0;
        end
        if (set_en) ref_busy[set_a] = 1'b1;
        @(negedge clk);
        ifc.wb_valid = 1'b0;
        chk("busy_mask", ifc.busy_mask, ref_busy);
    endtask

    task automatic drive_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = a;
        ifc.wb_data  = d;
        #1;
        chk("rf_write_enable", ifc.rf_write_enable, 1);
        chk("rf_write_addr", ifc.rf_write_addr, a);
        chk("rf_write_data", ifc.rf_write_data, d);
    endtask

    task automatic idle_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive_wb(a, d);
        tick(1'b0, '0);
        chk("idle_dec_ready", ifc.dec_ready, 1);
        chk("idle_iss_valid", ifc.iss_valid, 0);
    endtask

    // Full instruction: accept, fetch (with forced/random writebacks), hold.
    task automatic do_instr(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                            input logic [AW-1:0] d, input bit w, input int hold,
                            input int wb_at, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit rnd,
                            output logic [DW-1:0] obs1, output logic [DW-1:0] obs2);
        bit captured, h1, h2;
        logic [DW-1:0] e1, e2;
        captured = 1'b0;
        e1 = '0;
        e2 = '0;
        chk("dec_ready_idle", ifc.dec_ready, 1);
        ifc.dec_valid = 1'b1;
        ifc.dec_src1  = s1;
        ifc.dec_src2  = s2;
        ifc.dec_dst   = d;
        ifc.dec_wr    = w;
        tick(1'b0, '0);
        ifc.dec_valid = 1'b0;
        chk("dec_ready_fetch", ifc.dec_ready, 0);
        chk("iss_valid_after_accept", ifc.iss_valid, 0);
        for (int i = 0; i < 40 && !captured; i++) begin
            chk("rf_read_addr1", ifc.rf_read_addr1, s1);
            chk("rf_read_addr2", ifc.rf_read_addr2, s2);
            if (i == wb_at)
                drive_wb(wa, wd);
            else if (rnd) begin
                if (i >= 8 && ref_busy[s1])
                    drive_wb(s1, DW'($urandom_range(0, 255)));
                else if (i >= 8 && ref_busy[s2])
                    drive_wb(s2, DW'($urandom_range(0, 255)));
                else if ($urandom_range(0, 2) == 0)
                    drive_wb(AW'($urandom_range(0, NR-1)), DW'($urandom_range(0, 255)));
            end
            h1 = ifc.wb_valid && (ifc.wb_addr == s1);
            h2 = ifc.wb_valid && (ifc.wb_addr == s2);
            captured = (!ref_busy[s1] || h1) && (!ref_busy[s2] || h2);
            e1 = h1 ? ifc.wb_data : ref_regs[s1];
            e2 = h2 ? ifc.wb_data : ref_regs[s2];
            tick(captured && w, d);
            chk("iss_valid_fetch", ifc.iss_valid, captured);
        end
        chk("fetch_completed", captured, 1);
        chk("iss_op1", ifc.iss_op1, e1);
        chk("iss_op2", ifc.iss_op2, e2);
        chk("iss_dst", ifc.iss_dst, d);
        chk("iss_wr", ifc.iss_wr, w);
        obs1 = ifc.iss_op1;
        obs2 = ifc.iss_op2;
        for (int h = 0; h < hold; h++) begin
            ifc.iss_ready = 1'b0;
            ifc.dec_valid = 1'b1;
            ifc.dec_src1  = AW'($urandom_range(0, NR-1));
            ifc.dec_src2  = AW'($urandom_range(0, NR-1));
            ifc.dec_dst   = AW'($urandom_range(0, NR-1));
            ifc.dec_wr    = 1'($urandom_range(0, 1));
            if (rnd && $urandom_range(0, 1) == 0)
                drive_wb(AW'($urandom_range(0, NR-1)), DW'($urandom_range(0, 255)));
            tick(1'b0, '0);
            chk("hold_iss_valid", ifc.iss_valid, 1);
            chk("hold_dec_ready", ifc.dec_ready, 0);
            chk("hold_op1", ifc.iss_op1, e1);
            chk("hold_op2", ifc.iss_op2, e2);
            chk("hold_dst", ifc.iss_dst, d);
            chk("hold_wr", ifc.iss_wr, w);
        end
        ifc.dec_valid = 1'b0;
        ifc.iss_ready = 1'b1;
        tick(1'b0, '0);
        ifc.iss_ready = 1'b0;
        chk("release_iss_valid", ifc.iss_valid, 0);
        chk("release_dec_ready", ifc.dec_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] o1, o2;
        ifc.dec_valid = 1'b0;
        ifc.dec_src1  = '0;
        ifc.dec_src2  = '0;
        ifc.dec_dst   = '0;
        ifc.dec_wr    = 1'b0;
        ifc.iss_ready = 1'b0;
        ifc.wb_valid  = 1'b0;
        ifc.wb_addr   = '0;
        ifc.wb_data   = '0;
        ref_busy      = '0;

        // reset state
        #1;
        chk("reset_busy", ifc.busy_mask, 0);
        chk("reset_iss_valid", ifc.iss_valid, 0);
        chk("reset_dec_ready", ifc.dec_ready, 1);
        chk("reset_rd_addr1", ifc.rf_read_addr1, 0);
        chk("reset_op1", ifc.iss_op1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // preload every register through the write port
        for (int r = 0; r < NR; r++) idle_wb(AW'(r), DW'($urandom_range(0, 255)));

        // bypass-free read of a freshly written register, src1 == src2
        idle_wb(3'd3, 8'h5A);
        do_instr(3'd3, 3'd3, 3'd4, 1'b1, 0, -1, '0, '0, 1'b0, o1, o2);
        chk("t1_op1", o1, 8'h5A);
        chk("t1_op2", o2, 8'h5A);
        chk("t1_busy", ifc.busy_mask, 8'h10);

        // stall on busy r4, released by a bypassed writeback on fetch cycle 3
        do_instr(3'd4, 3'd0, 3'd1, 1'b0, 0, 2, 3'd4, 8'h77, 1'b0, o1, o2);
        chk("t2_op1_bypass", o1, 8'h77);
        chk("t2_busy", ifc.busy_mask, 8'h00);

        // 5 cycles of backpressure in HOLD with a pending decode
        do_instr(3'd1, 3'd2, 3'd7, 1'b0, 5, -1, '0, '0, 1'b0, o1, o2);

        // capture with dst=2 while r2 is written back on the same edge
        do_instr(3'd1, 3'd0, 3'd2, 1'b1, 0, 0, 3'd2, 8'h33, 1'b0, o1, o2);
        chk("t4_busy_set_wins", ifc.busy_mask, 8'h04);

        // wr=0 leaves the scoreboard alone; writeback to a non-busy register
        do_instr(3'd0, 3'd1, 3'd5, 1'b0, 1, -1, '0, '0, 1'b0, o1, o2);
        chk("t5_busy", ifc.busy_mask, 8'h04);
        idle_wb(3'd6, 8'h11);
        chk("t5_busy_after_wb", ifc.busy_mask, 8'h04);

        // src == own dst: no self stall; r6 carries the earlier write
        do_instr(3'd3, 3'd6, 3'd3, 1'b1, 0, -1, '0, '0, 1'b0, o1, o2);
        chk("t6_op2", o2, 8'h11);
        chk("t6_busy", ifc.busy_mask, 8'h0C);

        // asynchronous reset while stalled in FETCH on busy r2
        ifc.dec_valid = 1'b1;
        ifc.dec_src1  = 3'd2;
        ifc.dec_src2  = 3'd0;
        ifc.dec_dst   = 3'd1;
        ifc.dec_wr    = 1'b1;
        tick(1'b0, '0);
        ifc.dec_valid = 1'b0;
        tick(1'b0, '0);
        chk("t7_stalled", ifc.iss_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy", ifc.busy_mask, 0);
        chk("t7_rst_iss_valid", ifc.iss_valid, 0);
        chk("t7_rst_dec_ready", ifc.dec_ready, 1);
        ref_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle_wb(AW'($urandom_range(0, NR-1)), DW'($urandom_range(0, 255)));
            do_instr(AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)),
                     AW'($urandom_range(0, NR-1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), -1, '0, '0, 1'b1, o1, o2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
